// File: rtl/act_pkg.sv
// Shared definitions for the activation stream unit.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package act_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_RELU   = 2'd1;
  localparam logic [1:0] MODE_LEAKY  = 2'd2;
  localparam logic [1:0] MODE_CLIP   = 2'd3;

  // Width needed to hold a count of 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/act_lane.sv
// Single-element activation: bypass, ReLU, leaky ReLU or clipped ReLU.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module act_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [1:0]                   mode,
  input  logic [DATA_WIDTH-2:0]        clip_val,
  input  logic signed [DATA_WIDTH-1:0] x,
  output logic signed [DATA_WIDTH-1:0] y
);

  logic                   neg;
  logic signed [DATA_WIDTH-1:0] clip_ext;

  assign neg      = x[DATA_WIDTH-1];
  // Ceiling is unsigned, so it is always a non-negative signed value.
  assign clip_ext = {1'b0, clip_val};

  // Select the activation; negative inputs are the only ones most modes touch.
  always_comb begin
    y = x;
    case (mode)
      MODE_RELU:  if (neg) y = '0;
      MODE_LEAKY: if (neg) y = x >>> LEAK_SHIFT;
      MODE_CLIP: begin
        if (neg)                y = '0;
        else if (x > clip_ext)  y = clip_ext;
      end
      default:    y = x;
    endcase
  end

endmodule

// File: rtl/act_stream_unit.sv
// Streams LANES-wide beats through a per-tensor-latched activation, adds framing and negative count.
// Latency: 2 cycles from input acceptance to out_valid; one beat per cycle sustained.
// Backpressure: two-stage valid/ready pipeline; in_ready drops only when both stages are full and stalled.
module act_stream_unit
  import act_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int LANES       = 4,
  parameter int TENSOR_SIZE = 16,
  parameter int LEAK_SHIFT  = 3
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [1:0]                          mode,
  input  logic [DATA_WIDTH-2:0]               clip_val,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]         in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*DATA_WIDTH-1:0]         out_data,
  output logic                                out_last,
  output logic [count_width(TENSOR_SIZE)-1:0] out_neg_count
);

  localparam int BEATS = TENSOR_SIZE / LANES;
  localparam int CNT_W = count_width(TENSOR_SIZE);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = DATA_WIDTH;

  logic [BW-1:0]         beat_cnt;
  logic [1:0]            mode_q;
  logic [DW-2:0]         clip_q;
  logic [CNT_W-1:0]      neg_acc;

  logic                  first_beat;
  logic                  last_beat;
  logic [1:0]            eff_mode;
  logic [DW-2:0]         eff_clip;
  logic [CNT_W-1:0]      beat_neg;
  logic [CNT_W-1:0]      neg_total;
  logic [LANES*DW-1:0]   lane_out;

  logic                  s1_vld;
  logic [LANES*DW-1:0]   s1_dat;
  logic                  s1_last;
  logic [CNT_W-1:0]      s1_cnt;
  logic                  s2_vld;
  logic [LANES*DW-1:0]   s2_dat;
  logic                  s2_last;
  logic [CNT_W-1:0]      s2_cnt;

  logic                  s2_free;
  logic                  accept;

  assign s2_free  = !s2_vld || out_ready;
  assign in_ready = !s1_vld || s2_free;
  assign accept   = in_valid && in_ready;

  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == BW'(BEATS - 1));

  // The first beat of a tensor uses the live controls, which are latched on that same beat.
  assign eff_mode = first_beat ? mode : mode_q;
  assign eff_clip = first_beat ? clip_val : clip_q;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      act_lane #(
        .DATA_WIDTH (DW),
        .LEAK_SHIFT (LEAK_SHIFT)
      ) u_lane (
        .mode     (eff_mode),
        .clip_val (eff_clip),
        .x        (in_data[g*DW +: DW]),
        .y        (lane_out[g*DW +: DW])
      );
    end
  endgenerate

  // Count lanes whose sign bit is set in the incoming beat.
  always_comb begin
    beat_neg = '0;
    for (int k = 0; k < LANES; k++) begin
      beat_neg = beat_neg + CNT_W'(in_data[k*DW + DW - 1]);
    end
  end

  assign neg_total = (first_beat ? '0 : neg_acc) + beat_neg;

  // Tensor framing state: beat position, latched controls, running negative count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      mode_q   <= MODE_RELU;
      clip_q   <= '0;
      neg_acc  <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
      neg_acc  <= neg_total;
      if (first_beat) begin
        mode_q <= mode;
        clip_q <= clip_val;
      end
    end
  end

  // Stage 1: activated lanes plus framing, loaded whenever it is empty or draining.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_dat  <= '0;
      s1_last <= 1'b0;
      s1_cnt  <= '0;
    end else if (in_ready) begin
      s1_vld <= accept;
      if (accept) begin
        s1_dat  <= lane_out;
        s1_last <= last_beat;
        s1_cnt  <= neg_total;
      end
    end
  end

  // Stage 2: output register, holds steady while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld  <= 1'b0;
      s2_dat  <= '0;
      s2_last <= 1'b0;
      s2_cnt  <= '0;
    end else if (s2_free) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_dat  <= s1_dat;
        s2_last <= s1_last;
        s2_cnt  <= s1_cnt;
      end
    end
  end

  assign out_valid     = s2_vld;
  assign out_data      = s2_dat;
  assign out_last      = s2_vld && s2_last;
  assign out_neg_count = (s2_vld && s2_last) ? s2_cnt : '0;

endmodule
